// File: rtl/vma_ext_pkg.sv
// Shared encodings for the extended VMA block: operation and reference
// types, section-source selects and break-mask bit positions.
package vma_ext_pkg;

    localparam int VMA_OP_W = 2;
    localparam int MASK_W   = 3;
    localparam int MAGIC_W  = 9;

    typedef enum logic [1:0] {
        VMA_HOLD    = 2'b00,
        VMA_LOAD    = 2'b01,
        VMA_PCMAGIC = 2'b10,
        VMA_INC     = 2'b11
    } vma_op_e;

    typedef enum logic [1:0] {
        REF_FETCH = 2'b00,
        REF_READ  = 2'b01,
        REF_WRITE = 2'b10,
        REF_NONE  = 2'b11
    } ref_type_e;

    localparam logic [1:0] VMAX_VMA  = 2'b00;
    localparam logic [1:0] VMAX_PC   = 2'b01;
    localparam logic [1:0] VMAX_PREV = 2'b10;
    localparam logic [1:0] VMAX_AD   = 2'b11;

    localparam int MASK_FETCH = 0;
    localparam int MASK_READ  = 1;
    localparam int MASK_WRITE = 2;

endpackage

// File: rtl/vma_ext_if.sv
// Bundle of all control, data and status signals between the VMA block
// and its neighbours (EDP, MCL/CON, PAG/CSH).
interface vma_ext_if
    import vma_ext_pkg::*;
#(
    parameter int SECT_W     = 5,
    parameter int OFF_W      = 18,
    parameter int N_BRK      = 2,
    parameter int HIST_DEPTH = 8
);
    localparam int W  = SECT_W + OFF_W;
    localparam int IW = $clog2(N_BRK) + 1;
    localparam int CW = $clog2(HIST_DEPTH) + 1;

    logic [VMA_OP_W-1:0] vma_op;
    logic                inc_global;
    logic [1:0]          vmax_sel;
    logic [W-1:0]        ad;
    logic [MAGIC_W-1:0]  magic;
    logic                load_pc;
    logic                load_held;
    logic                sel_held;
    logic                load_prev_ctx;
    logic                extended;
    logic                ref_valid;
    logic [1:0]          ref_type;
    logic                brk_wr;
    logic [IW-1:0]       brk_idx;
    logic [W-1:0]        brk_addr;
    logic [MASK_W-1:0]   brk_mask;
    logic                brk_clr;
    logic                hist_rd;

    logic [W-1:0]        vma;
    logic [W-1:0]        pc;
    logic [W-1:0]        held_or_pc;
    logic [SECT_W-1:0]   prev_sec;
    logic                ac_ref;
    logic [N_BRK-1:0]    brk_hit;
    logic                brk_pulse;
    logic [W-1:0]        hist_data;
    logic [CW-1:0]       hist_count;
    logic                hist_empty;

    modport master (
        output vma_op, inc_global, vmax_sel, ad, magic, load_pc, load_held,
               sel_held, load_prev_ctx, extended, ref_valid, ref_type,
               brk_wr, brk_idx, brk_addr, brk_mask, brk_clr, hist_rd,
        input  vma, pc, held_or_pc, prev_sec, ac_ref, brk_hit, brk_pulse,
               hist_data, hist_count, hist_empty
    );

    modport slave (
        input  vma_op, inc_global, vmax_sel, ad, magic, load_pc, load_held,
               sel_held, load_prev_ctx, extended, ref_valid, ref_type,
               brk_wr, brk_idx, brk_addr, brk_mask, brk_clr, hist_rd,
        output vma, pc, held_or_pc, prev_sec, ac_ref, brk_hit, brk_pulse,
               hist_data, hist_count, hist_empty
    );

endinterface

// File: rtl/vma_ext_hist_ring.sv
// PC-history circular buffer. When full, a push overwrites the oldest
// entry; a pop on an empty buffer is dropped.
module vma_hist_ring #(
    parameter int W     = 23,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               push_data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, do_pop, rd_adv;

    // Pointer and occupancy bookkeeping; a full push drags the read pointer along.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop_i && (count_q != '0);
        rd_adv  = do_pop || (push_i && full);
        wr_d    = push_i ? wr_q + AW'(1) : wr_q;
        rd_d    = rd_adv ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(push_i) - CW'(rd_adv);
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are masked by empty_o so they need no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/vma_ext.sv
// Extended virtual memory address block: VMA/PC/HELD/previous section,
// fast-AC reference detect, address-break channels and PC history.
module vma_ext
    import vma_ext_pkg::*;
#(
    parameter int SECT_W     = 5,
    parameter int OFF_W      = 18,
    parameter int N_BRK      = 2,
    parameter int HIST_DEPTH = 8
) (
    input  logic      clk,
    input  logic      CROBAR,
    vma_ext_if.slave  bus
);
    localparam int W  = SECT_W + OFF_W;
    localparam int IW = $clog2(N_BRK) + 1;

    logic [W-1:0]      vma_q, vma_d;
    logic [W-1:0]      pc_q, held_q;
    logic [SECT_W-1:0] prev_q;
    logic [SECT_W-1:0] vma_sect;
    logic [OFF_W-1:0]  vma_off;
    logic [N_BRK-1:0]  match;
    logic [N_BRK-1:0]  hit_vec;
    logic              pulse_q;
    logic              is_local;

    assign vma_sect = vma_q[W-1:OFF_W];
    assign vma_off  = vma_q[OFF_W-1:0];

    // Next VMA from the requested operation.
    always_comb begin
        logic [SECT_W-1:0] sect_sel;
        logic              carry;
        vma_d    = vma_q;
        sect_sel = vma_sect;
        carry    = 1'b0;
        case (vma_op_e'(bus.vma_op))
            VMA_LOAD: begin
                case (bus.vmax_sel)
                    VMAX_VMA:  sect_sel = vma_sect;
                    VMAX_PC:   sect_sel = pc_q[W-1:OFF_W];
                    VMAX_PREV: sect_sel = prev_q;
                    default:   sect_sel = bus.ad[W-1:OFF_W];
                endcase
                vma_d = {sect_sel, bus.ad[OFF_W-1:0]};
            end
            VMA_PCMAGIC: begin
                // Offset arithmetic wraps inside the section.
                vma_d = {pc_q[W-1:OFF_W],
                         pc_q[OFF_W-1:0] + {{(OFF_W-MAGIC_W){1'b0}}, bus.magic}};
            end
            VMA_INC: begin
                carry = (&vma_off) & bus.inc_global;
                vma_d = {vma_sect + SECT_W'(carry), vma_off + OFF_W'(1)};
            end
            default: vma_d = vma_q;
        endcase
    end

    // Address registers; PC and HELD sample the VMA from before this edge.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            vma_q  <= '0;
            pc_q   <= '0;
            held_q <= '0;
            prev_q <= '0;
        end else begin
            vma_q <= vma_d;
            if (bus.load_pc)       pc_q   <= vma_q;
            if (bus.load_held)     held_q <= vma_q;
            if (bus.load_prev_ctx) prev_q <= bus.ad[W-1:OFF_W];
        end
    end

    // Fast-AC detect: data reference to a local section, offset below 16.
    always_comb begin
        is_local   = !bus.extended || (bus.ref_type == REF_FETCH)
                     || (vma_sect <= SECT_W'(1));
        bus.ac_ref = bus.ref_valid && (bus.ref_type != REF_FETCH) && is_local
                     && (vma_off[OFF_W-1:4] == '0);
    end

    for (genvar i = 0; i < N_BRK; i++) begin : g_brk
        logic [W-1:0]      addr_q;
        logic [MASK_W-1:0] mask_q;
        logic              hit_q;
        logic              sel;
        logic              type_en;

        assign sel = (bus.brk_idx == IW'(i));

        // Mask bit for the current reference type; type 11 never enables.
        always_comb begin
            type_en = 1'b0;
            case (ref_type_e'(bus.ref_type))
                REF_FETCH: type_en = mask_q[MASK_FETCH];
                REF_READ:  type_en = mask_q[MASK_READ];
                REF_WRITE: type_en = mask_q[MASK_WRITE];
                default:   type_en = 1'b0;
            endcase
        end

        assign match[i] = bus.ref_valid && type_en && (vma_q == addr_q);

        // Channel config and sticky hit; a new hit beats a concurrent clear.
        always_ff @(posedge clk) begin
            if (CROBAR) begin
                addr_q <= '0;
                mask_q <= '0;
                hit_q  <= 1'b0;
            end else begin
                if (bus.brk_wr && sel) begin
                    addr_q <= bus.brk_addr;
                    mask_q <= bus.brk_mask;
                end
                if (match[i])               hit_q <= 1'b1;
                else if (bus.brk_clr && sel) hit_q <= 1'b0;
            end
        end

        assign hit_vec[i] = hit_q;
    end

    // One-cycle break pulse for any channel matching at the last edge.
    always_ff @(posedge clk) begin
        if (CROBAR) pulse_q <= 1'b0;
        else        pulse_q <= |match;
    end

    vma_hist_ring #(
        .W     (W),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk         (clk),
        .rst         (CROBAR),
        .push_i      (bus.load_pc),
        .pop_i       (bus.hist_rd),
        .push_data_i (pc_q),
        .data_o      (bus.hist_data),
        .count_o     (bus.hist_count),
        .empty_o     (bus.hist_empty)
    );

    assign bus.vma        = vma_q;
    assign bus.pc         = pc_q;
    assign bus.held_or_pc = bus.sel_held ? held_q : pc_q;
    assign bus.prev_sec   = prev_q;
    assign bus.brk_hit    = hit_vec;
    assign bus.brk_pulse  = pulse_q;

endmodule
